// File: rtl/layer1_pkg.sv
// Shared constants and state encoding for the layer-1 result writer.
package layer1_pkg;

  localparam int unsigned WORDLENGTH = 16;
  localparam int unsigned FRAC_BITS  = 10;
  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned PIXELS     = 1024;
  localparam int unsigned MEM_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/layer1_bias_relu_sat.sv
// One channel of bias add with saturation to the signed word range and optional ReLU.
module layer1_bias_relu_sat #(
  parameter int unsigned WORDLENGTH = 16,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic [WORDLENGTH-1:0] ch,
  input  logic [WORDLENGTH-1:0] bias,
  output logic [WORDLENGTH-1:0] res_c
);

  logic [WORDLENGTH:0]   sum;
  logic [WORDLENGTH-1:0] sat;

  always_comb begin
    sum = {ch[WORDLENGTH-1], ch} + {bias[WORDLENGTH-1], bias};
    sat = sum[WORDLENGTH-1:0];
    // Sign bit and the bit below disagree only on overflow; sum[W] is the true sign.
    if (sum[WORDLENGTH] != sum[WORDLENGTH-1]) begin
      sat = sum[WORDLENGTH] ? {1'b1, {(WORDLENGTH-1){1'b0}}}
                            : {1'b0, {(WORDLENGTH-1){1'b1}}};
    end
    res_c = sat;
    if (RELU_EN && sat[WORDLENGTH-1]) begin
      res_c = '0;
    end
  end

endmodule

// File: rtl/layer1_result_writer.sv
// Layer-1 back end: bias/saturate/ReLU eight channels, pack into four 32-bit words
// and stream them to the feature-map SRAM with frame-level pixel and address tracking.
module layer1_result_writer #(
  parameter int unsigned WORDLENGTH = layer1_pkg::WORDLENGTH,
  parameter int unsigned NUM_CH     = layer1_pkg::NUM_CH,
  parameter int unsigned PIXELS     = layer1_pkg::PIXELS,
  parameter int unsigned ADDR_W     = 16,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*WORDLENGTH-1:0] in_data,
  input  logic [NUM_CH*WORDLENGTH-1:0] bias,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic                         mem_we,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         done
);

  import layer1_pkg::*;

  localparam int unsigned VEC_W = NUM_CH * WORDLENGTH;
  localparam int unsigned PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic [PIX_W-1:0]  pix_idx_q;
  logic [1:0]        k_q;
  logic [VEC_W-1:0]  res_q;
  logic [VEC_W-1:0]  res_c;
  logic [ADDR_W-1:0] base_q;
  logic              last_pix;
  logic              last_word;
  logic              word_acc;
  logic              load;
  logic              latch_base;

  // Channel order is preserved: channel 1 stays in the MSBs of the result bank.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    layer1_bias_relu_sat #(
      .WORDLENGTH (WORDLENGTH),
      .RELU_EN    (RELU_EN)
    ) u_sat (
      .ch    (in_data[c*WORDLENGTH +: WORDLENGTH]),
      .bias  (bias[c*WORDLENGTH +: WORDLENGTH]),
      .res_c (res_c[c*WORDLENGTH +: WORDLENGTH])
    );
  end

  assign last_pix  = (pix_idx_q == PIX_W'(PIXELS - 1));
  assign last_word = (k_q == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_ready && last_word) begin
          if (last_pix)      state_d = ST_DONE;
          else if (in_valid) state_d = ST_WRITE;
          else               state_d = ST_IDLE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls; in_ready follows mem_ready so pixels chain without bubbles.
  always_comb begin
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    word_acc   = 1'b0;
    mem_wdata  = 32'h0;
    case (state_q)
      ST_IDLE:  in_ready = 1'b1;
      ST_WRITE: begin
        mem_we   = 1'b1;
        word_acc = mem_ready;
        in_ready = last_word && mem_ready && !last_pix;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
    if (rst) in_ready = 1'b0;
    load       = in_valid && in_ready;
    latch_base = load && (state_q == ST_IDLE) && (pix_idx_q == '0);
    case (k_q)
      2'd0:    mem_wdata = res_q[VEC_W-1    -: 32];
      2'd1:    mem_wdata = res_q[VEC_W-33   -: 32];
      2'd2:    mem_wdata = res_q[VEC_W-65   -: 32];
      default: mem_wdata = res_q[VEC_W-97   -: 32];
    endcase
    mem_addr = base_q + ADDR_W'({pix_idx_q, k_q});
  end

  // Result bank, word/pixel counters and frame base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      k_q       <= 2'd0;
      pix_idx_q <= '0;
      base_q    <= '0;
    end else begin
      if (load) begin
        res_q <= res_c;
        k_q   <= 2'd0;
      end else if (word_acc) begin
        k_q <= k_q + 2'd1;
      end
      if (latch_base) base_q <= base_addr;
      if (state_q == ST_DONE) begin
        pix_idx_q <= '0;
      end else if (word_acc && last_word && !last_pix) begin
        pix_idx_q <= pix_idx_q + PIX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_layer1_result_writer.sv
// Directed bench for layer1_result_writer: a ReLU/16-bit-address instance and a
// no-ReLU/8-bit-address instance share stimulus, 4-pixel frames.
module tb_layer1_result_writer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         mem_ready;
  logic [127:0] in_data;
  logic [127:0] bias;
  logic [15:0]  base_addr;

  logic         in_ready,  mem_we,  done;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         in_ready2, mem_we2, done2;
  logic [7:0]   mem_addr2;
  logic [31:0]  mem_wdata2;

  int errors;
  int checks;

  layer1_result_writer #(.PIXELS(4), .ADDR_W(16), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .base_addr(base_addr),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done)
  );

  layer1_result_writer #(.PIXELS(4), .ADDR_W(8), .RELU_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .bias(bias), .base_addr(base_addr[7:0]),
    .mem_we(mem_we2), .mem_ready(mem_ready), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] SEQ_DATA = {16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                       16'h0005, 16'h0006, 16'h0007, 16'h0008};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Presents one vector, waits (bounded) for the handshake, and returns in the cycle word 0 is shown.
  task automatic send_pixel(input logic [127:0] d, input logic [127:0] b, input logic [15:0] base);
    int n;
    in_data = d;
    bias = b;
    base_addr = base;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL rst_in_ready2 got=%b exp=0", in_ready2); end
    in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send_pixel({16'h0400, 112'h0}, {16'h0200, 112'h0}, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL basic_we%0d got=%b exp=1", i, mem_we); end
      checks++;
      if (mem_addr !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL basic_addr%0d got=%h exp=%h", i, mem_addr, 16'h0100 + 16'(i));
      end
      checks++;
      if (mem_wdata !== ((i == 0) ? 32'h0600_0000 : 32'h0)) begin
        errors++; $display("FAIL basic_data%0d got=%h exp=%h", i, mem_wdata, (i == 0) ? 32'h0600_0000 : 32'h0);
      end
      cyc();
    end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_drop got=%b exp=0", mem_we); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_r [4] = '{32'h7FFF_0000, 32'h0000_1235, 32'h0000_7FFF, 32'h0000_0000};
    logic [31:0] exp_n [4] = '{32'h7FFF_8000, 32'h0000_1235, 32'h8000_7FFF, 32'hFFFF_FFFF};
    do_reset();
    send_pixel({16'h7F00, 16'h8000, 16'hFC00, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001},
               {16'h0200, 16'hFF00, 16'h0400, 16'h0001, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFE},
               16'h0000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_wdata !== exp_r[i]) begin
        errors++; $display("FAIL sat_relu_w%0d got=%h exp=%h", i, mem_wdata, exp_r[i]);
      end
      checks++;
      if (mem_wdata2 !== exp_n[i]) begin
        errors++; $display("FAIL sat_norelu_w%0d got=%h exp=%h", i, mem_wdata2, exp_n[i]);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_pixel(SEQ_DATA, 128'h0, 16'h0200);
    checks++; if (mem_addr !== 16'h0200) begin errors++; $display("FAIL bp_addr0 got=%h exp=0200", mem_addr); end
    cyc();
    mem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL bp_hold_we%0d got=%b exp=1", j, mem_we); end
      checks++; if (mem_addr !== 16'h0201) begin errors++; $display("FAIL bp_hold_addr%0d got=%h exp=0201", j, mem_addr); end
      checks++; if (mem_wdata !== 32'h0003_0004) begin errors++; $display("FAIL bp_hold_data%0d got=%h exp=00030004", j, mem_wdata); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready%0d got=%b exp=0", j, in_ready); end
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (mem_addr !== 16'h0201 || mem_wdata !== 32'h0003_0004) begin
      errors++; $display("FAIL bp_resume_w1 got=%h/%h exp=0201/00030004", mem_addr, mem_wdata);
    end
    cyc();
    checks++; if (mem_addr !== 16'h0202 || mem_wdata !== 32'h0005_0006) begin
      errors++; $display("FAIL bp_resume_w2 got=%h/%h exp=0202/00050006", mem_addr, mem_wdata);
    end
    cyc();
    checks++; if (mem_addr !== 16'h0203 || mem_wdata !== 32'h0007_0008) begin
      errors++; $display("FAIL bp_resume_w3 got=%h/%h exp=0203/00070008", mem_addr, mem_wdata);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_w3_in_ready got=%b exp=1", in_ready); end
    cyc();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bp_we_drop got=%b exp=0", mem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
    do_reset();
    in_data = SEQ_DATA;
    bias = 128'h0;
    base_addr = 16'h0010;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_start_ready got=%b exp=1", in_ready); end
    cyc();
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL b2b_we%0d got=%b exp=1", i, mem_we); end
      checks++;
      if (mem_addr !== 16'h0010 + 16'(i) || mem_addr2 !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL b2b_addr%0d got=%h/%h exp=%h", i, mem_addr, mem_addr2, 16'h0010 + 16'(i));
      end
      checks++;
      if (mem_wdata !== w[i % 4]) begin
        errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, mem_wdata, w[i % 4]);
      end
      checks++;
      if (in_ready !== ((i % 4 == 3) && (i != 15))) begin
        errors++; $display("FAIL b2b_in_ready%0d got=%b exp=%b", i, in_ready, (i % 4 == 3) && (i != 15));
      end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done%0d got=%b exp=0", i, done); end
      cyc();
    end
    base_addr = 16'h0040;
    checks++; if (done !== 1'b1 || done2 !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b/%b exp=1", done, done2); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_done_we got=%b exp=0", mem_we); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_in_ready got=%b exp=0", in_ready); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b exp=1", in_ready); end
    cyc();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_addr2 !== 8'h40) begin
      errors++; $display("FAIL b2b_new_base got=%b/%h/%h exp=1/0040/40", mem_we, mem_addr, mem_addr2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_tail_we got=%b exp=0", mem_we); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_data = SEQ_DATA;
    bias = 128'h0;
    base_addr = 16'h0300;
    in_valid = 1'b1;
    #1;
    cyc();
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (mem_addr !== 16'h030A) begin errors++; $display("FAIL mid_pre_addr got=%h exp=030a", mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_we2 !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%b/%b exp=0", mem_we, mem_we2); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    send_pixel(SEQ_DATA, 128'h0, 16'h0500);
    checks++;
    if (mem_addr !== 16'h0500 || mem_addr2 !== 8'h00 || mem_wdata !== 32'h0001_0002) begin
      errors++; $display("FAIL mid_restart got=%h/%h/%h exp=0500/00/00010002", mem_addr, mem_addr2, mem_wdata);
    end
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_tail_we got=%b exp=0", mem_we); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp8 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    send_pixel(SEQ_DATA, 128'h0, 16'h00FE);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_addr2 !== exp8[i]) begin
        errors++; $display("FAIL wrap_addr8_%0d got=%h exp=%h", i, mem_addr2, exp8[i]);
      end
      checks++;
      if (mem_addr !== 16'h00FE + 16'(i)) begin
        errors++; $display("FAIL wrap_addr16_%0d got=%h exp=%h", i, mem_addr, 16'h00FE + 16'(i));
      end
      cyc();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    in_data = '0;
    bias = '0;
    base_addr = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/layer1_result_writer.md
# layer1_result_writer

Sequential back end for the layer-1 1x1 convolution array. It accepts one pixel's eight Q6.10 channel results per handshake, then applies a per-channel bias with saturation and an optional ReLU. It packs the eight 16-bit results into four 32-bit words and writes them to the feature-map SRAM through a ready/valid write port. It counts pixels per frame, generates word addresses, and pulses `done` after the last pixel of the frame is written.

## Interface
- `WORDLENGTH`, 16: channel word width, signed Q6.10.
- `NUM_CH`, 8: channels per pixel (fixed 8; four packed words).
- `PIXELS`, 1024: pixels per frame (32x32).
- `ADDR_W`, 16: word-address width.
- `RELU_EN`, 1: 1 = clamp negatives to 0 after bias.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  result vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_data`  in  NUM_CH*WORDLENGTH  packed results; channel 1 in the MSBs [127:112], channel 8 in [15:0].
- `bias`  in  NUM_CH*WORDLENGTH  packed per-channel bias, same order and format; static during a frame.
- `base_addr`  in  ADDR_W  frame base word address, sampled when pixel 0 is accepted.
- `mem_we`  out  1  write request valid.
- `mem_ready`  in  1  SRAM accepts the write this cycle.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  packed word.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&&in_ready`: compute and register all eight results, set `k`=0, go to WRITE.
  - If `pix_idx`==0, latch `base_addr`.
- Per-channel arithmetic, in order:
  1. `s = sext17(ch) + sext17(bias)`.
  2. Saturate `s` to [-32768, 32767].
  3. If RELU_EN and the result is negative, output 0.
- Packing: word `k` = {res[2k+1 channel], res[2k+2 channel]}, so word 0 = {ch1, ch2} and word 3 = {ch7, ch8}.
- Address: `mem_addr = base_latched + pix_idx*4 + k`, modulo 2^ADDR_W (wraps silently).
- WRITE:
  - `mem_we`=1. `mem_addr` and `mem_wdata` are held stable until `mem_ready`.
  - On accept with `k`<3: `k`++.
  - On accept with `k`==3 and `pix_idx`<PIXELS-1: `pix_idx`++.
    - If `in_valid` is also high, load the next vector (see Timing) and stay in WRITE with `k`=0.
    - Otherwise go to IDLE.
  - On accept with `k`==3 and `pix_idx`==PIXELS-1: go to DONE; the last-word cycle does not accept input.
- DONE: `done`=1 for one cycle, `pix_idx`=0, `in_ready`=0, go to IDLE.
- Reset values: state IDLE, `pix_idx`=0, `k`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `in_ready`=0.
- Reset mid-frame: the partial pixel and frame are dropped; the next frame restarts at pixel 0 using a fresh `base_addr`.

## Timing
- `in_ready` = (state==IDLE) || (state==WRITE && k==3 && mem_ready && pix_idx<PIXELS-1).
  - It is combinational from `mem_ready`.
  - It is 0 while `rst` is asserted.
- Latency: from input accept at edge N, word 0 is presented (`mem_we`=1) in cycle N+1.
- Throughput with `mem_ready` held high: one pixel every 4 cycles, with no bubbles between pixels.
- `mem_we` drops the cycle after the last word accept unless the next pixel was loaded.
- `done` asserts the cycle after word 3 of pixel PIXELS-1 is accepted.
- `in_data` is registered at accept, so upstream may change it after the handshake.
- `bias` is sampled at accept, combinationally with `in_data`.

## Structure
- Shared package `layer1_pkg`:
  - constants WORDLENGTH, FRAC_BITS=10, NUM_CH, layer-1 PIXELS;
  - state enum `wr_state_t`.
- Sub-module `layer1_bias_relu_sat`: one combinational instance per channel, 16-bit in, 16-bit bias in, RELU_EN parameter, 16-bit out.
- The top level holds the FSM, result register bank, counters and address adder.

## Test plan
1. Basic path: RELU_EN=1, ch1=0x0400, bias1=0x0200, all other channels 0, mem_ready=1, base_addr=0x0100 -> words 0x06000000, 0, 0, 0 at addresses 0x0100–0x0103; `mem_we` high for exactly 4 cycles.
2. Saturation and ReLU:
   - ch=0x7F00 with bias 0x0200 -> 0x7FFF.
   - ch=0x8000 with bias 0xFF00 -> 0x0000 with RELU_EN=1; 0x8000 with RELU_EN=0.
   - ch=0xFC00 with bias 0x0400 -> 0x0000.
3. Backpressure: hold mem_ready=0 for 3 cycles during word 1 -> `mem_addr`/`mem_wdata` stable, `in_ready`=0 throughout, k unchanged; writes resume in order after release.
4. Back-to-back: PIXELS=4, in_valid always 1, mem_ready=1 -> 16 writes in 16 consecutive cycles to base..base+15, in_ready pulsing every 4th cycle, `done` high for exactly one cycle after the 16th write; the next frame starts at a newly sampled base.
5. Reset mid-operation: assert rst during pixel 2 word 2 -> `mem_we`=0 and `in_ready`=0 immediately; after release, the first pixel writes to the new base_addr+0 and pix_idx=0.
6. Address wrap: ADDR_W=8, base_addr=0xFE -> pixel 0 addresses 0xFE, 0xFF, 0x00, 0x01.
